// File: rtl/ifmap_pkg.sv
// ifmap_pkg: constants, field-position helpers and the FSM state type shared
// by the ifmap row server and its bench.
//
// Packet layout (PKT_W = 8 + IFMAP_SIZE bits):
//   [PKT_W-1:PKT_W-4] destination node id
//   [PKT_W-5:PKT_W-8] opcode
//   [IFMAP_SIZE-1:0]  row data
package ifmap_pkg;

  localparam logic [3:0] OP_START          = 4'd0;
  localparam logic [3:0] OP_PPE_INPUT      = 4'd1;
  localparam logic [3:0] OP_TS_DONE        = 4'd10;
  localparam logic [3:0] OP_ROWS_EXHAUSTED = 4'd11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_BCAST = 2'd2,
    ST_SERVE = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dest_msb(input int pkt_w);
    return pkt_w - 1;
  endfunction

  function automatic int dest_lsb(input int pkt_w);
    return pkt_w - 4;
  endfunction

  function automatic int op_msb(input int pkt_w);
    return pkt_w - 5;
  endfunction

  function automatic int op_lsb(input int pkt_w);
    return pkt_w - 8;
  endfunction

endpackage

// File: rtl/ifmap_row_store.sv
// ifmap_row_store: NUM_TS x S*S bit ifmap memory.
//   clk_i                 clock (memory has no reset, contents survive rst_n)
//   wr_en_i/wr_ts_i/wr_addr_i/wr_data_i   single-bit write port
//   rd_ts_i/rd_row_i      combinational row read
//   row_o                 row rd_row_i of timestep rd_ts_i, zero if row >= S
module ifmap_row_store
  import ifmap_pkg::*;
#(
  parameter int IFMAP_SIZE = 25,
  parameter int NUM_TS     = 2,
  parameter int ROW_W      = 5
) (
  input  logic                                        clk_i,
  input  logic                                        wr_en_i,
  input  logic [idx_w(NUM_TS)-1:0]                    wr_ts_i,
  input  logic [idx_w(IFMAP_SIZE*IFMAP_SIZE)-1:0]     wr_addr_i,
  input  logic                                        wr_data_i,
  input  logic [idx_w(NUM_TS)-1:0]                    rd_ts_i,
  input  logic [ROW_W-1:0]                            rd_row_i,
  output logic [IFMAP_SIZE-1:0]                       row_o
);

  localparam int BITS = IFMAP_SIZE * IFMAP_SIZE;

  logic [BITS-1:0] mem_q [NUM_TS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ts_i][wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    row_o = '0;
    if (int'(rd_row_i) < IFMAP_SIZE) begin
      row_o = mem_q[rd_ts_i][int'(rd_row_i) * IFMAP_SIZE +: IFMAP_SIZE];
    end
  end

endmodule

// File: rtl/ifmap_row_server.sv
// ifmap_row_server: stores ifmap bits for NUM_TS timesteps and serves rows to
// NUM_PE partial-product PEs over a packet channel.
//   clk, rst_n                       clock, async active-low reset
//   wr_valid/wr_ready/wr_ts/wr_addr/wr_data   bit load port (LOAD only)
//   load_done                        ends the load phase
//   in_valid/in_ready/in_pkt         requests from the router
//   out_valid/out_ready/out_pkt      replies/broadcasts to the router
//   cur_ts                           active timestep
//   err                              sticky protocol error
//   state_dbg                        current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready. A
// producer holds valid and payload stable until the transfer; out_pkt never
// changes while out_valid && !out_ready. Only one request is in flight: the
// input is closed while a reply is pending or presented.
module ifmap_row_server
  import ifmap_pkg::*;
#(
  parameter int IFMAP_SIZE = 25,
  parameter int NUM_PE     = 5,
  parameter int NUM_TS     = 2,
  parameter int PE_BASE_ID = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [idx_w(NUM_TS)-1:0]                wr_ts,
  input  logic [idx_w(IFMAP_SIZE*IFMAP_SIZE)-1:0] wr_addr,
  input  logic                                    wr_data,
  input  logic                                    load_done,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [8+IFMAP_SIZE-1:0]                 in_pkt,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [8+IFMAP_SIZE-1:0]                 out_pkt,
  output logic [idx_w(NUM_TS)-1:0]                cur_ts,
  output logic                                    err,
  output state_e                                  state_dbg
);

  localparam int PKT_W = 8 + IFMAP_SIZE;
  localparam int TS_W  = idx_w(NUM_TS);
  // Pointers can overshoot S by up to NUM_PE-1 after the last valid row.
  localparam int PTR_W = idx_w(IFMAP_SIZE + NUM_PE);
  localparam int PE_W  = idx_w(NUM_PE + 1);
  localparam int OP_HI = op_msb(PKT_W);
  localparam int OP_LO = op_lsb(PKT_W);

  state_e               state_q, state_d;
  logic [TS_W-1:0]      cur_ts_q, cur_ts_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [PKT_W-1:0]     out_pkt_q, out_pkt_d;
  logic [PE_W-1:0]      idx_q, idx_d;         // next broadcast row
  logic                 pend_q, pend_d;       // accepted row request awaiting reply
  logic [PE_W-1:0]      pend_k_q, pend_k_d;   // PE index of that request
  logic [PTR_W-1:0]     ptr_q [NUM_PE];
  logic [PTR_W-1:0]     ptr_d [NUM_PE];

  logic                 in_fire, out_fire, wr_en;
  logic [3:0]           in_op;
  logic [31:0]          op_ext;
  logic [PTR_W-1:0]     rd_row;
  logic [IFMAP_SIZE-1:0] row_data;

  assign wr_ready  = (state_q == ST_LOAD);
  assign in_ready  = ((state_q == ST_READY) || (state_q == ST_SERVE)) && !out_valid_q && !pend_q;
  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign cur_ts    = cur_ts_q;
  assign err       = err_q;
  assign state_dbg = state_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign wr_en    = wr_valid && wr_ready;
  assign in_op    = in_pkt[OP_HI:OP_LO];
  assign op_ext   = 32'(in_op);
  assign rd_row   = (state_q == ST_BCAST) ? PTR_W'(idx_q) : ptr_q[pend_k_q];

  ifmap_row_store #(
    .IFMAP_SIZE (IFMAP_SIZE),
    .NUM_TS     (NUM_TS),
    .ROW_W      (PTR_W)
  ) u_store (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_ts_i   (wr_ts),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_ts_i   (cur_ts_q),
    .rd_row_i  (rd_row),
    .row_o     (row_data)
  );

  always_comb begin
    state_d     = state_q;
    cur_ts_d    = cur_ts_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_k_d    = pend_k_q;
    for (int i = 0; i < NUM_PE; i++) ptr_d[i] = ptr_q[i];

    case (state_q)
      ST_LOAD: begin
        if (load_done) state_d = ST_READY;
      end

      ST_READY: begin
        if (in_fire) begin
          if (in_op == OP_START) begin
            state_d = ST_BCAST;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_BCAST: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          // Leave only once the last row has actually been taken.
          if (idx_q == PE_W'(NUM_PE)) begin
            state_d = ST_SERVE;
            for (int i = 0; i < NUM_PE; i++) ptr_d[i] = PTR_W'(NUM_PE + i);
          end
        end else if (!out_valid_q && (idx_q < PE_W'(NUM_PE))) begin
          out_valid_d = 1'b1;
          out_pkt_d   = {4'(PE_BASE_ID + int'(idx_q)), OP_PPE_INPUT, row_data};
          idx_d       = idx_q + PE_W'(1);
        end
      end

      ST_SERVE: begin
        if (out_fire) out_valid_d = 1'b0;
        if (pend_q) begin
          // Reply is built one cycle after acceptance.
          pend_d      = 1'b0;
          out_valid_d = 1'b1;
          if (ptr_q[pend_k_q] >= PTR_W'(IFMAP_SIZE)) begin
            out_pkt_d = {4'(PE_BASE_ID + int'(pend_k_q)), OP_ROWS_EXHAUSTED, {IFMAP_SIZE{1'b0}}};
          end else begin
            out_pkt_d = {4'(PE_BASE_ID + int'(pend_k_q)), OP_PPE_INPUT, row_data};
            ptr_d[pend_k_q] = ptr_q[pend_k_q] + PTR_W'(NUM_PE);
          end
        end else if (in_fire) begin
          if (in_op == OP_TS_DONE) begin
            if (cur_ts_q == TS_W'(NUM_TS - 1)) begin
              err_d = 1'b1;
            end else begin
              cur_ts_d = cur_ts_q + TS_W'(1);
              state_d  = ST_BCAST;
              idx_d    = '0;
            end
          end else if ((op_ext >= 32'(PE_BASE_ID)) && (op_ext < 32'(PE_BASE_ID + NUM_PE))) begin
            pend_d   = 1'b1;
            pend_k_d = PE_W'(op_ext - 32'(PE_BASE_ID));
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cur_ts_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_k_q    <= '0;
      for (int i = 0; i < NUM_PE; i++) ptr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_ts_q    <= cur_ts_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_k_q    <= pend_k_d;
      for (int i = 0; i < NUM_PE; i++) ptr_q[i] <= ptr_d[i];
    end
  end

endmodule
